// File: rtl/sbox_layer_serial.sv
`default_nettype none
// ============================================================================
// Module   : sbox_layer_serial
// Purpose  : Serial Spongent S-box layer. Captures a round state and streams
//            one substituted byte per handshake, lowest byte first.
// Revision : 1.0 - initial release
// ============================================================================
module sbox_layer_serial #(
    parameter int NBYTES = 33,
    parameter int IDX_W  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [8*NBYTES-1:0]   state_in,
    input  logic                  out_ready,
    output logic [7:0]            byte_out,
    output logic [IDX_W-1:0]      index_out,
    output logic                  byte_valid,
    output logic                  busy,
    output logic                  done
);

    localparam int                 c_CNT_W = $clog2(NBYTES + 1);
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(NBYTES - 1);
    localparam logic [c_CNT_W-1:0] c_END   = c_CNT_W'(NBYTES);

    localparam logic [0:0] c_IDLE = 1'b0;
    localparam logic [0:0] c_RUN  = 1'b1;

    logic [0:0]           r_state;
    logic [0:0]           w_next_state;
    logic [8*NBYTES-1:0]  r_data;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [c_CNT_W-1:0]   r_index;
    logic [7:0]           r_byte;
    logic                 r_valid;
    logic                 r_done;

    logic                 w_capture;
    logic                 w_load;
    logic                 w_xfer;
    logic                 w_last;
    logic [7:0]           w_sel;

    function automatic logic [3:0] f_sbox(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'hE;  4'h1: y = 4'hD;  4'h2: y = 4'hB;  4'h3: y = 4'h0;
            4'h4: y = 4'h2;  4'h5: y = 4'h1;  4'h6: y = 4'h4;  4'h7: y = 4'hF;
            4'h8: y = 4'h7;  4'h9: y = 4'hA;  4'hA: y = 4'h8;  4'hB: y = 4'h5;
            4'hC: y = 4'h9;  4'hD: y = 4'hC;  4'hE: y = 4'h3;  default: y = 4'h6;
        endcase
        return y;
    endfunction

    // Byte mux over the captured state; out-of-range counts select zero.
    always_comb begin
        w_sel = 8'h00;
        for (int i = 0; i < NBYTES; i++) begin
            if (r_cnt == c_CNT_W'(i)) begin
                w_sel = r_data[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_capture    = 1'b0;
        w_load       = 1'b0;
        w_last       = 1'b0;
        w_xfer       = r_valid && out_ready;
        case (r_state)
            c_IDLE: begin
                if (start) begin
                    w_next_state = c_RUN;
                    w_capture    = 1'b1;
                end
            end
            default: begin
                w_load = (!r_valid || out_ready) && (r_cnt < c_END);
                w_last = w_xfer && (r_index == c_LAST);
                if (w_last) begin
                    w_next_state = c_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_capture) begin
            r_data <= state_in;
        end
    end

    // A load on the same edge as a transfer keeps the stream gap-free.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt   <= '0;
            r_index <= '0;
            r_byte  <= 8'h00;
            r_valid <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= w_last;
            if (w_capture) begin
                r_cnt <= '0;
            end
            if (w_load) begin
                r_byte  <= {f_sbox(w_sel[7:4]), f_sbox(w_sel[3:0])};
                r_index <= r_cnt;
                r_cnt   <= r_cnt + c_CNT_W'(1);
                r_valid <= 1'b1;
            end else if (w_xfer) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign byte_out   = r_byte;
    assign index_out  = IDX_W'(r_index);
    assign byte_valid = r_valid;
    assign busy       = (r_state == c_RUN);
    assign done       = r_done;

endmodule
`default_nettype wire

// File: tb/tb_sbox_layer_serial.sv
`default_nettype none
// ============================================================================
// Module   : tb_sbox_layer_serial
// Purpose  : Directed self-checking bench for sbox_layer_serial.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sbox_layer_serial;

    localparam int c_NBYTES = 33;
    localparam int c_IDX_W  = 32;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    start;
    logic [8*c_NBYTES-1:0]   state_in;
    logic                    out_ready;
    logic [7:0]              byte_out;
    logic [c_IDX_W-1:0]      index_out;
    logic                    byte_valid;
    logic                    busy;
    logic                    done;

    int n_cmp = 0;
    int n_bad = 0;

    sbox_layer_serial #(.NBYTES(c_NBYTES), .IDX_W(c_IDX_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .state_in   (state_in),
        .out_ready  (out_ready),
        .byte_out   (byte_out),
        .index_out  (index_out),
        .byte_valid (byte_valid),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Hand-computed: S(3)=0,S(F)=6 -> 0x06; S(A)=8,S(5)=1 -> 0x81; S(0)=E -> 0xEE.
    function automatic logic [7:0] exp_mixed(input int i);
        if (i == 0) return 8'h06;
        if (i == 1) return 8'h81;
        return 8'hEE;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst       = 1'b0;
        start     = 1'b1;
        out_ready = 1'b1;
        state_in  = '0;

        // Reset held with start asserted
        tick();
        tick();
        chk("rst byte_out",   32'(byte_out),   32'h0);
        chk("rst index_out",  index_out,       32'h0);
        chk("rst byte_valid", 32'(byte_valid), 32'h0);
        chk("rst busy",       32'(busy),       32'h0);
        chk("rst done",       32'(done),       32'h0);

        rst   = 1'b1;
        start = 1'b0;
        tick();
        chk("idle busy", 32'(busy), 32'h0);

        // Pass 1: all-zero state, ready always high
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("p1 busy at start",  32'(busy),       32'h1);
        chk("p1 valid at start", 32'(byte_valid), 32'h0);
        for (int i = 0; i < c_NBYTES; i++) begin
            tick();
            chk($sformatf("p1 byte[%0d]", i),  32'(byte_out),   32'hEE);
            chk($sformatf("p1 index[%0d]", i), index_out,       32'(i));
            chk($sformatf("p1 valid[%0d]", i), 32'(byte_valid), 32'h1);
            chk($sformatf("p1 busy[%0d]", i),  32'(busy),       32'h1);
            chk($sformatf("p1 done[%0d]", i),  32'(done),       32'h0);
        end
        tick();
        chk("p1 done pulse", 32'(done),       32'h1);
        chk("p1 busy end",   32'(busy),       32'h0);
        chk("p1 valid end",  32'(byte_valid), 32'h0);

        // Pass 2 started back-to-back in the done cycle
        state_in        = '0;
        state_in[7:0]   = 8'h3F;
        state_in[15:8]  = 8'hA5;
        start           = 1'b1;
        tick();
        start    = 1'b0;
        state_in = '0;
        chk("p2 done cleared", 32'(done), 32'h0);
        chk("p2 busy",         32'(busy), 32'h1);
        for (int i = 0; i < c_NBYTES; i++) begin
            tick();
            start = 1'b0;
            chk($sformatf("p2 byte[%0d]", i),  32'(byte_out),   32'(exp_mixed(i)));
            chk($sformatf("p2 index[%0d]", i), index_out,       32'(i));
            chk($sformatf("p2 valid[%0d]", i), 32'(byte_valid), 32'h1);
            if (i == 7) begin
                out_ready = 1'b0;
                for (int s = 0; s < 5; s++) begin
                    tick();
                    chk($sformatf("stall byte[%0d]", s),  32'(byte_out),   32'hEE);
                    chk($sformatf("stall index[%0d]", s), index_out,       32'd7);
                    chk($sformatf("stall valid[%0d]", s), 32'(byte_valid), 32'h1);
                end
                out_ready = 1'b1;
            end
            if (i == 10) begin
                start    = 1'b1;
                state_in = '1;
            end
        end
        tick();
        chk("p2 done pulse", 32'(done), 32'h1);
        chk("p2 busy end",   32'(busy), 32'h0);
        tick();
        chk("p2 done single", 32'(done), 32'h0);

        // Pass 3: aborted by reset at index 20
        state_in = '0;
        start    = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i <= 20; i++) begin
            tick();
            chk($sformatf("p3 index[%0d]", i), index_out, 32'(i));
        end
        rst = 1'b0;
        tick();
        rst = 1'b1;
        chk("abort valid", 32'(byte_valid), 32'h0);
        chk("abort busy",  32'(busy),       32'h0);
        chk("abort index", index_out,       32'h0);
        chk("abort done",  32'(done),       32'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("abort no done[%0d]", i), 32'(done), 32'h0);
            chk($sformatf("abort idle[%0d]", i),    32'(busy), 32'h0);
        end

        // Pass 4: new start after abort restarts at index 0
        state_in       = '0;
        state_in[7:0]  = 8'h3F;
        state_in[15:8] = 8'hA5;
        start          = 1'b1;
        tick();
        start = 1'b0;
        chk("p4 busy", 32'(busy), 32'h1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("p4 byte[%0d]", i),  32'(byte_out), 32'(exp_mixed(i)));
            chk($sformatf("p4 index[%0d]", i), index_out,     32'(i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
